instr_fetch_unit: RTL and testbench

- Upstream stage of the 21-bit single-cycle core. It holds the PC, fetches 21-bit instruction words from instruction memory over a req/ready handshake, and presents the latched instruction and its decoded fields to the control unit and datapath.
- It consumes the control unit's branch/jump outputs (beq, bne, j) and the ALU zero flag. With these it computes the next PC at the end of each execute cycle.

---
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the 21-bit core: owns the PC, fetches over a req/ready
// handshake, latches the instruction and resolves the next PC after execute.
//
// Memory handshake: imem_req is high in every FETCH cycle with imem_addr == pc.
// A word transfers on the rising edge where imem_req and imem_ready are both high.
// imem_rdata is ignored in all other cycles.
module instr_fetch_unit #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [4:0]      HALT_OP  = 5'b11111
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [20:0]     imem_rdata,
  input  logic            stall,
  input  logic            beq,
  input  logic            bne,
  input  logic            j,
  input  logic            zero,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus1,
  output logic [20:0]     instr,
  output logic            instr_valid,
  output logic [4:0]      opCode,
  output logic [2:0]      rs,
  output logic [2:0]      rt,
  output logic [2:0]      rd,
  output logic [2:0]      funct,
  output logic [9:0]      imm,
  output logic [15:0]     jtarget,
  output logic            halted,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [20:0]     instr_nxt;
  logic [PC_W-1:0] imm_sx;
  logic [PC_W-1:0] jt_pc;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] next_pc;

  assign opCode  = instr[20:16];
  assign rs      = instr[15:13];
  assign rt      = instr[12:10];
  assign rd      = instr[9:7];
  assign funct   = instr[2:0];
  assign imm     = instr[9:0];
  assign jtarget = instr[15:0];

  assign imem_addr   = pc;
  assign pc_plus1    = pc + PC_W'(1);
  assign imem_req    = (state == S_FETCH);
  assign instr_valid = (state == S_EXEC);
  assign halted      = (state == S_HALT);
  assign state_dbg   = state;

  // Size casts give sign extension of imm and zero-extend/truncate of jtarget.
  assign imm_sx    = PC_W'($signed(imm));
  assign jt_pc     = PC_W'(jtarget);
  assign br_target = pc_plus1 + imm_sx;

  always_comb begin
    next_pc = pc_plus1;
    if (j)
      next_pc = jt_pc;
    else if (beq && zero)
      next_pc = br_target;
    else if (bne && !zero)
      next_pc = br_target;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          instr_nxt = imem_rdata;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        // Control inputs only matter on the cycle the stall releases.
        if (!stall) begin
          if (opCode == HALT_OP) begin
            state_nxt = S_HALT;
          end else begin
            pc_nxt    = next_pc;
            state_nxt = S_FETCH;
          end
        end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      instr <= instr_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed program walk plus randomized traffic,
// checked every cycle against a transaction-level model of the fetch rules.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [20:0] imem_rdata;
  logic        stall = 1'b0;
  logic        beq = 1'b0, bne = 1'b0, j = 1'b0, zero = 1'b0;
  logic [15:0] pc, pc_plus1;
  logic [20:0] instr;
  logic        instr_valid;
  logic [4:0]  opCode;
  logic [2:0]  rs, rt, rd, funct;
  logic [9:0]  imm;
  logic [15:0] jtarget;
  logic        halted;
  logic [1:0]  state_dbg;

  logic [20:0] mem [0:65535];
  logic [15:0] exp_q [$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;

  // Memory returns garbage (inverted word) when not ready; it must never be latched.
  assign imem_rdata = imem_ready ? mem[imem_addr] : ~mem[imem_addr];

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .beq(beq), .bne(bne), .j(j), .zero(zero), .pc(pc), .pc_plus1(pc_plus1),
    .instr(instr), .instr_valid(instr_valid), .opCode(opCode), .rs(rs),
    .rt(rt), .rd(rd), .funct(funct), .imm(imm), .jtarget(jtarget),
    .halted(halted), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_HALT = 3;
  int          m_ph;
  logic [15:0] m_pc;
  logic [20:0] m_instr;

  function automatic logic [15:0] model_next(input logic [15:0] p, input logic [20:0] w,
                                             input logic b_eq, input logic b_ne,
                                             input logic jj, input logic z);
    int off, t;
    off = int'(w[9:0]);
    if (off >= 512) off = off - 1024;
    if (jj) return w[15:0];
    if ((b_eq && z) || (b_ne && !z)) t = int'(p) + 1 + off;
    else t = int'(p) + 1;
    t = t % 65536;
    if (t < 0) t = t + 65536;
    return t[15:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph    <= M_IDLE;
      m_pc    <= 16'h0000;
      m_instr <= '0;
    end else begin
      case (m_ph)
        M_IDLE:  m_ph <= M_FETCH;
        M_FETCH: if (imem_ready) begin m_instr <= mem[m_pc]; m_ph <= M_EXEC; end
        M_EXEC:  if (!stall) begin
                   if (m_instr[20:16] == 5'b11111) m_ph <= M_HALT;
                   else begin
                     m_pc <= model_next(m_pc, m_instr, beq, bne, j, zero);
                     m_ph <= M_FETCH;
                   end
                 end
        default: m_ph <= M_HALT;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [15:0] p1;
    p1 = 16'((int'(m_pc) + 1) % 65536);
    check("pc", pc, m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("pc_plus1", pc_plus1, p1);
    check("instr", instr, m_instr);
    check("fields", {opCode, rs, rt, rd, funct, imm, jtarget},
          {m_instr[20:16], m_instr[15:13], m_instr[12:10], m_instr[9:7],
           m_instr[2:0], m_instr[9:0], m_instr[15:0]});
    check("ctrl", {imem_req, instr_valid, halted},
          {m_ph == M_FETCH, m_ph == M_EXEC, m_ph == M_HALT});
  end

  // ---------------- driver tasks ----------------
  task automatic wait_exec();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!instr_valid && n < 40);
    check("exec_reached", instr_valid, 1'b1);
  endtask

  task automatic exec_step(input logic b_eq, input logic b_ne, input logic jj, input logic z);
    beq = b_eq; bne = b_ne; j = jj; zero = z; stall = 1'b0;
    @(posedge clk); #1;
    beq = 1'b0; bne = 1'b0; j = 1'b0; zero = 1'b0;
  endtask

  task automatic step_to_next();
    exec_step(1'b0, 1'b0, 1'b0, 1'b0);
    wait_exec();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int last_cyc;
    logic [1:0] st_hold;
    for (int a = 0; a < 65536; a++) mem[a] = {5'b00010, 16'(a)};
    mem[10]       = {5'd3, 6'd0, 10'h3FE};
    mem[11]       = {5'd3, 6'd0, 10'h3FE};
    mem[20]       = {5'd4, 16'h0100};
    mem[16'h0101] = {5'd4, 16'hFFFF};

    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", pc, 16'h0000);
    check("rst_instr", instr, 21'h0);
    check("rst_ctrl", {imem_req, instr_valid, halted}, 3'b000);
    check("rst_opcode", opCode, 5'h00);

    // Sequential fetch with immediate ready.
    rst = 1'b0;
    @(negedge clk); check("req_bubble", imem_req, 1'b0);
    @(negedge clk); check("req_rise", imem_req, 1'b1);
    for (int k = 0; k <= 4; k++) exp_q.push_back(16'(k));
    last_cyc = 0;
    for (int k = 0; k <= 4; k++) begin
      wait_exec();
      check("seq_pc", pc, exp_q.pop_front());
      if (k > 0) check("seq_gap", cyc - last_cyc, 2);
      last_cyc = cyc;
      if (k == 4) imem_ready = 1'b0;
      exec_step(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Three wait-state cycles at pc=5, data on the fourth.
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      check("ws_hold", {imem_req, instr_valid, pc}, {1'b1, 1'b0, 16'd5});
    end
    @(posedge clk); #1;
    imem_ready = 1'b1;
    wait_exec();
    check("ws_instr", instr, {5'b00010, 16'd5});
    for (int k = 6; k <= 10; k++) step_to_next();

    // Branches around pc=10.
    check("br_at10", pc, 16'd10);
    exec_step(1'b1, 1'b0, 1'b0, 1'b1); wait_exec();
    check("beq_taken", pc, 16'd9);
    step_to_next();
    exec_step(1'b1, 1'b0, 1'b0, 1'b0); wait_exec();
    check("beq_not_taken", pc, 16'd11);
    mem[10] = {5'd3, 6'd0, 10'h004};
    exec_step(1'b1, 1'b0, 1'b0, 1'b1); wait_exec();
    check("back_to10", pc, 16'd10);
    check("new_imm", imm, 10'h004);
    exec_step(1'b0, 1'b1, 1'b0, 1'b0); wait_exec();
    check("bne_taken", pc, 16'd15);
    for (int k = 16; k <= 20; k++) step_to_next();

    // Jump outranks a taken beq.
    exec_step(1'b1, 1'b0, 1'b1, 1'b1); wait_exec();
    check("jump_prio", pc, 16'h0100);

    // Stall holds EXEC while beq toggles.
    stall = 1'b1; beq = 1'b1; zero = 1'b1;
    for (int s = 0; s < 2; s++) begin
      @(posedge clk); #1;
      check("stall_hold", {instr_valid, pc, instr}, {1'b1, 16'h0100, mem[16'h0100]});
      beq = ~beq;
    end
    step_to_next();
    check("after_stall", pc, 16'h0101);

    // Wrap from 0xFFFF to 0.
    mem[7] = {5'b11111, 16'h1234};
    exec_step(1'b0, 1'b0, 1'b1, 1'b0); wait_exec();
    check("jump_ffff", pc, 16'hFFFF);
    check("plus1_wrap", pc_plus1, 16'h0000);
    step_to_next();
    check("pc_wrap", pc, 16'h0000);

    // Halt at pc=7.
    for (int k = 1; k <= 7; k++) step_to_next();
    check("halt_op", opCode, 5'b11111);
    exec_step(1'b0, 1'b0, 1'b1, 1'b0);
    st_hold = state_dbg;
    for (int h = 0; h < 10; h++) begin
      @(negedge clk);
      check("halt_hold", {halted, instr_valid, imem_req, pc}, {1'b1, 1'b0, 1'b0, 16'd7});
      check("halt_state", state_dbg, st_hold);
    end

    // Asynchronous reset between edges.
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst", {pc, halted, instr_valid}, {16'h0000, 1'b0, 1'b0});
    @(posedge clk); #1;

    // Randomized traffic against the model.
    for (int a = 0; a < 65536; a++)
      mem[a] = {($urandom_range(0, 39) == 0) ? 5'b11111 : 5'($urandom_range(0, 30)),
                16'($urandom)};
    rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (halted || $urandom_range(0, 499) == 0) rst = 1'b1;
      else rst = 1'b0;
      imem_ready = ($urandom_range(0, 3) != 0);
      stall      = ($urandom_range(0, 3) == 0);
      beq        = 1'($urandom);
      bne        = 1'($urandom);
      j          = ($urandom_range(0, 5) == 0);
      zero       = 1'($urandom);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
